// File: rtl/crop_engine_if.sv
// Source/destination memory bus of the crop engine.
//   rd_en/rd_addr : source read strobe and address (engine -> memory)
//   rd_data       : source read data, RD_LAT cycles after rd_en (memory -> engine)
//   wr_en/wr_addr/wr_data : destination write port (engine -> memory)
// master = crop engine, slave = memory side.
interface crop_engine_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 16
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (output rd_en, rd_addr, wr_en, wr_addr, wr_data, input rd_data);
   modport slave  (input rd_en, rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/crop_engine.sv
// Region-of-interest copier. On start, reads the inclusive window
// [x_min..x_max] x [y_min..y_max] of a column-major, CHANNELS-word-per-pixel
// image and writes it densely to the destination starting at HDR_WORDS,
// zero-padding every output line (one x column) to a multiple of ROW_ALIGN.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   start                 : begin a job (only honoured in IDLE/DONE)
//   x_min..y_max          : inclusive window bounds, latched on start
//   busy, done, err       : job status; err valid while done
//   words_written         : writes issued in current/last job (pad included)
//   mem (master)          : source read / destination write bus
module crop_engine #(
   parameter int IMG_W     = 100,
   parameter int IMG_H     = 100,
   parameter int CHANNELS  = 3,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 24,
   parameter int COORD_W   = 11,
   parameter int HDR_WORDS = 54,
   parameter int RD_LAT    = 1,
   parameter int ROW_ALIGN = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [COORD_W-1:0] x_min,
   input  logic [COORD_W-1:0] x_max,
   input  logic [COORD_W-1:0] y_min,
   input  logic [COORD_W-1:0] y_max,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [ADDR_W-1:0]  words_written,
   crop_engine_if.master      mem
);

   localparam int PW = $clog2(ROW_ALIGN) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_READ, S_WAIT, S_WRITE, S_PAD, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [COORD_W-1:0] xmn_q, xmn_d, xmx_q, xmx_d, ymn_q, ymn_d, ymx_q, ymx_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [1:0]         c_q, c_d;
   logic [2:0]         wait_q, wait_d;
   logic [PW-1:0]      pad_len_q, pad_len_d, pad_cnt_q, pad_cnt_d;
   logic               err_q, err_d;
   logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d, words_q, words_d;

   logic               rd_en, wr_en, eol, bad;
   logic [DATA_W-1:0]  wr_data;
   logic [ADDR_W-1:0]  line_len;

   function automatic logic [ADDR_W-1:0] src_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y,
                                                  input logic [1:0]         c);
      return (ADDR_W'(x) * ADDR_W'(IMG_H) + ADDR_W'(y)) * ADDR_W'(CHANNELS) + ADDR_W'(c);
   endfunction

   assign bad = (xmn_q > xmx_q) || (ymn_q > ymx_q) ||
                (int'(xmx_q) >= IMG_W) || (int'(ymx_q) >= IMG_H);

   // Words per output line; the pad count is its negation modulo ROW_ALIGN.
   assign line_len = (ADDR_W'(ymx_q) - ADDR_W'(ymn_q) + ADDR_W'(1)) * ADDR_W'(CHANNELS);

   always_comb begin
      state_d   = state_q;
      xmn_d     = xmn_q;
      xmx_d     = xmx_q;
      ymn_d     = ymn_q;
      ymx_d     = ymx_q;
      x_d       = x_q;
      y_d       = y_q;
      c_d       = c_q;
      wait_d    = wait_q;
      pad_len_d = pad_len_q;
      pad_cnt_d = pad_cnt_q;
      err_d     = err_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      words_d   = words_q;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      wr_data   = '0;
      eol       = 1'b0;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_CHECK;
               xmn_d     = x_min;
               xmx_d     = x_max;
               ymn_d     = y_min;
               ymx_d     = y_max;
               words_d   = '0;
               wr_addr_d = ADDR_W'(HDR_WORDS);
               err_d     = 1'b0;
            end
         end
         S_CHECK: begin
            if (bad) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               x_d       = xmn_q;
               y_d       = ymn_q;
               c_d       = '0;
               pad_len_d = PW'(ADDR_W'(0) - line_len) & PW'(ROW_ALIGN - 1);
               state_d   = S_READ;
            end
         end
         S_READ: begin
            rd_en = 1'b1;
            if (RD_LAT > 1) begin
               wait_d  = 3'(RD_LAT > 1 ? RD_LAT - 2 : 0);
               state_d = S_WAIT;
            end else begin
               state_d = S_WRITE;
            end
         end
         S_WAIT: begin
            if (wait_q == 3'd0) state_d = S_WRITE;
            else                wait_d  = wait_q - 3'd1;
         end
         S_WRITE: begin
            wr_en     = 1'b1;
            wr_data   = mem.rd_data;
            wr_addr_d = wr_addr_q + ADDR_W'(1);
            words_d   = words_q + ADDR_W'(1);
            if (c_q != 2'(CHANNELS - 1)) begin
               c_d     = c_q + 2'd1;
               state_d = S_READ;
            end else if (y_q != ymx_q) begin
               c_d     = '0;
               y_d     = y_q + COORD_W'(1);
               state_d = S_READ;
            end else if (pad_len_q != '0) begin
               pad_cnt_d = pad_len_q - PW'(1);
               state_d   = S_PAD;
            end else begin
               eol = 1'b1;
            end
         end
         S_PAD: begin
            wr_en     = 1'b1;
            wr_addr_d = wr_addr_q + ADDR_W'(1);
            words_d   = words_q + ADDR_W'(1);
            if (pad_cnt_q == '0) eol = 1'b1;
            else                 pad_cnt_d = pad_cnt_q - PW'(1);
         end
         default: state_d = S_IDLE;
      endcase

      // Line finished: next x column or job complete.
      if (eol) begin
         if (x_q == xmx_q) begin
            state_d = S_DONE;
         end else begin
            x_d     = x_q + COORD_W'(1);
            y_d     = ymn_q;
            c_d     = '0;
            state_d = S_READ;
         end
      end

      // rd_addr is registered so it is stable in READ and holds otherwise.
      if (state_d == S_READ) rd_addr_d = src_addr(x_d, y_d, c_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         xmn_q     <= '0;
         xmx_q     <= '0;
         ymn_q     <= '0;
         ymx_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         c_q       <= '0;
         wait_q    <= '0;
         pad_len_q <= '0;
         pad_cnt_q <= '0;
         err_q     <= 1'b0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         words_q   <= '0;
      end else begin
         state_q   <= state_d;
         xmn_q     <= xmn_d;
         xmx_q     <= xmx_d;
         ymn_q     <= ymn_d;
         ymx_q     <= ymx_d;
         x_q       <= x_d;
         y_q       <= y_d;
         c_q       <= c_d;
         wait_q    <= wait_d;
         pad_len_q <= pad_len_d;
         pad_cnt_q <= pad_cnt_d;
         err_q     <= err_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         words_q   <= words_d;
      end
   end

   // Strobes decode from the state register so reset removes them at once.
   assign mem.rd_en   = rd_en;
   assign mem.rd_addr = rd_addr_q;
   assign mem.wr_en   = wr_en;
   assign mem.wr_addr = wr_addr_q;
   assign mem.wr_data = wr_data;

   assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done          = (state_q == S_DONE);
   assign err           = err_q;
   assign words_written = words_q;

endmodule

// File: tb/tb_crop_engine.sv
// Directed bench for crop_engine: default-parameter DUT (u0) and a
// RD_LAT=2 / CHANNELS=1 / ROW_ALIGN=1 DUT (u1), each with a memory model.
module tb_crop_engine;
   localparam int AW = 24;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   logic          start0 = 0, start1 = 0;
   logic [10:0]   xa0 = 0, xb0 = 0, ya0 = 0, yb0 = 0;
   logic [10:0]   xa1 = 0, xb1 = 0, ya1 = 0, yb1 = 0;
   logic          busy0, done0, err0, busy1, done1, err1;
   logic [AW-1:0] ww0, ww1;

   crop_engine_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
   crop_engine_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

   crop_engine u0 (
      .clk(clk), .rst_n(rst_n), .start(start0),
      .x_min(xa0), .x_max(xb0), .y_min(ya0), .y_max(yb0),
      .busy(busy0), .done(done0), .err(err0), .words_written(ww0), .mem(if0));

   crop_engine #(.CHANNELS(1), .RD_LAT(2), .ROW_ALIGN(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .x_min(xa1), .x_max(xb1), .y_min(ya1), .y_max(yb1),
      .busy(busy1), .done(done1), .err(err1), .words_written(ww1), .mem(if1));

   function automatic logic [DW-1:0] f0(input logic [AW-1:0] a);
      return 16'(a) ^ 16'hC3C3;
   endfunction
   function automatic logic [DW-1:0] f1(input logic [AW-1:0] a);
      return 16'(a) + 16'h1234;
   endfunction

   // Memory models: data is only meaningful exactly RD_LAT cycles after rd_en.
   logic [DW-1:0] rd0 = 0, p1 = 0, rd1 = 0;
   always @(posedge clk) begin
      rd0 <= if0.rd_en ? f0(if0.rd_addr) : 16'hBAD0;
      p1  <= if1.rd_en ? f1(if1.rd_addr) : 16'hBAD1;
      rd1 <= p1;
   end
   assign if0.rd_data = rd0;
   assign if1.rd_data = rd1;

   int r0a[$], r0c[$], w0a[$], w0c[$], r1a[$], r1c[$], w1a[$], w1c[$];
   logic [DW-1:0] w0d[$], w1d[$];
   int coll = 0;

   always @(negedge clk) begin
      if (if0.rd_en) begin r0a.push_back(int'(if0.rd_addr)); r0c.push_back(cyc); end
      if (if0.wr_en) begin w0a.push_back(int'(if0.wr_addr)); w0d.push_back(if0.wr_data); w0c.push_back(cyc); end
      if (if1.rd_en) begin r1a.push_back(int'(if1.rd_addr)); r1c.push_back(cyc); end
      if (if1.wr_en) begin w1a.push_back(int'(if1.wr_addr)); w1d.push_back(if1.wr_data); w1c.push_back(cyc); end
      if ((if0.rd_en && if0.wr_en) || (if1.rd_en && if1.wr_en)) coll++;
   end

   // Runs one job; start is held for 'hold' extra cycles with scrambled bounds.
   task automatic do_job(input bit sel, input int xmn, input int xmx, input int ymn, input int ymx,
                         input int hold, output int lat, output bit to, output bit bsy);
      int acc;
      if (!sel) begin r0a.delete(); r0c.delete(); w0a.delete(); w0d.delete(); w0c.delete(); end
      else      begin r1a.delete(); r1c.delete(); w1a.delete(); w1d.delete(); w1c.delete(); end
      @(negedge clk);
      if (!sel) begin xa0 = 11'(xmn); xb0 = 11'(xmx); ya0 = 11'(ymn); yb0 = 11'(ymx); start0 = 1; end
      else      begin xa1 = 11'(xmn); xb1 = 11'(xmx); ya1 = 11'(ymn); yb1 = 11'(ymx); start1 = 1; end
      @(posedge clk);
      #1;
      acc = cyc;
      if (hold == 0) begin start0 = 0; start1 = 0; end
      @(negedge clk);
      bsy = sel ? busy1 : busy0;
      for (int h = 0; h < hold; h++) begin
         xa0 = 0; xb0 = 50; ya0 = 7; yb0 = 9; xa1 = 0; xb1 = 50; ya1 = 7; yb1 = 9;
         if (h == hold - 1) begin start0 = 0; start1 = 0; end
         if (h != hold - 1) @(negedge clk);
      end
      to = 1;
      for (int i = 0; i < 300; i++) begin
         if (sel ? done1 : done0) begin to = 0; break; end
         @(negedge clk);
      end
      lat = cyc - acc;
   endtask

   task automatic test_reset();
      rst_n = 0;
      @(posedge clk);
      #1;
      checks++;
      if ({busy0, done0, err0, if0.rd_en, if0.wr_en, busy1, done1, err1, if1.rd_en, if1.wr_en} !== 10'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 0", {busy0, done0, err0, if0.rd_en, if0.wr_en, busy1, done1, err1, if1.rd_en, if1.wr_en});
      end
      checks++;
      if ({if0.rd_addr, if0.wr_addr, if0.wr_data, ww0} !== '0) begin
         errors++; $display("FAIL reset_bus: rd_addr %0d wr_addr %0d wr_data %0h ww %0d expected 0", if0.rd_addr, if0.wr_addr, if0.wr_data, ww0);
      end
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_default();
      int lat; bit to, bsy;
      int era[$]; logic [DW-1:0] ewd[$];
      for (int x = 1; x <= 2; x++) begin
         for (int y = 3; y <= 4; y++)
            for (int c = 0; c < 3; c++) begin
               era.push_back((x * 100 + y) * 3 + c);
               ewd.push_back(f0(AW'((x * 100 + y) * 3 + c)));
            end
         ewd.push_back(16'h0); ewd.push_back(16'h0);
      end
      do_job(0, 1, 2, 3, 4, 0, lat, to, bsy);
      checks++; if (to) begin errors++; $display("FAIL default_timeout: done not seen"); end
      checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL default_busy: got %b expected 1", bsy); end
      checks++; if (lat != 29) begin errors++; $display("FAIL default_latency: got %0d expected 29", lat); end
      checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL default_err: got %b expected 0", err0); end
      checks++; if (ww0 !== 24'd16) begin errors++; $display("FAIL default_words: got %0d expected 16", ww0); end
      checks++; if (r0a.size() != 12 || w0a.size() != 16) begin
         errors++; $display("FAIL default_counts: reads %0d writes %0d expected 12 16", r0a.size(), w0a.size());
      end
      checks++; if (r0a.size() == 0 || r0a[0] != 309) begin
         errors++; $display("FAIL default_first_rd: got %0d expected 309", r0a.size() ? r0a[0] : -1);
      end
      for (int i = 0; i < r0a.size() && i < 12; i++) begin
         checks++; if (r0a[i] != era[i]) begin errors++; $display("FAIL default_rd[%0d]: got %0d expected %0d", i, r0a[i], era[i]); end
      end
      for (int i = 0; i < w0a.size() && i < 16; i++) begin
         checks++;
         if (w0a[i] != 54 + i || w0d[i] !== ewd[i]) begin
            errors++; $display("FAIL default_wr[%0d]: got @%0d=%h expected @%0d=%h", i, w0a[i], w0d[i], 54 + i, ewd[i]);
         end
      end
      checks++; if (coll != 0) begin errors++; $display("FAIL rd_wr_overlap: got %0d cycles expected 0", coll); end
   endtask

   task automatic test_single_pixel();
      int lat; bit to, bsy;
      logic [DW-1:0] ewd[4];
      ewd[0] = f0(24'd0); ewd[1] = f0(24'd1); ewd[2] = f0(24'd2); ewd[3] = 16'h0;
      do_job(0, 0, 0, 0, 0, 0, lat, to, bsy);
      checks++; if (to || lat != 8) begin errors++; $display("FAIL single_latency: got %0d (timeout %b) expected 8", lat, to); end
      checks++; if (r0a.size() != 3 || w0a.size() != 4) begin
         errors++; $display("FAIL single_counts: reads %0d writes %0d expected 3 4", r0a.size(), w0a.size());
      end
      for (int i = 0; i < r0a.size() && i < 3; i++) begin
         checks++; if (r0a[i] != i) begin errors++; $display("FAIL single_rd[%0d]: got %0d expected %0d", i, r0a[i], i); end
      end
      for (int i = 0; i < w0a.size() && i < 4; i++) begin
         checks++;
         if (w0a[i] != 54 + i || w0d[i] !== ewd[i]) begin
            errors++; $display("FAIL single_wr[%0d]: got @%0d=%h expected @%0d=%h", i, w0a[i], w0d[i], 54 + i, ewd[i]);
         end
      end
   endtask

   task automatic test_reject();
      int lat; bit to, bsy;
      do_job(0, 5, 4, 0, 100, 0, lat, to, bsy);
      checks++; if (to || lat != 1) begin errors++; $display("FAIL reject_latency: got %0d (timeout %b) expected 1", lat, to); end
      checks++; if ({done0, err0, busy0} !== 3'b110) begin errors++; $display("FAIL reject_status: got done/err/busy %b expected 110", {done0, err0, busy0}); end
      repeat (3) @(negedge clk);
      checks++; if (r0a.size() != 0 || w0a.size() != 0) begin
         errors++; $display("FAIL reject_access: reads %0d writes %0d expected 0 0", r0a.size(), w0a.size());
      end
      // Out-of-range y alone must also be rejected.
      do_job(0, 0, 0, 0, 100, 0, lat, to, bsy);
      checks++; if (to || err0 !== 1'b1 || r0a.size() != 0) begin
         errors++; $display("FAIL reject_ymax: err %b reads %0d expected 1 0", err0, r0a.size());
      end
   endtask

   task automatic test_read_latency();
      int lat; bit to, bsy;
      do_job(1, 0, 0, 0, 1, 0, lat, to, bsy);
      checks++; if (to || lat != 7) begin errors++; $display("FAIL lat2_latency: got %0d (timeout %b) expected 7", lat, to); end
      checks++; if (w1a.size() != 2 || r1a.size() != 2) begin
         errors++; $display("FAIL lat2_counts: reads %0d writes %0d expected 2 2", r1a.size(), w1a.size());
      end else begin
         checks++; if (w1c[1] - w1c[0] != 3) begin errors++; $display("FAIL lat2_spacing: got %0d expected 3", w1c[1] - w1c[0]); end
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (r1a[i] != i || w1c[i] - r1c[i] != 2 || w1a[i] != 54 + i || w1d[i] !== f1(AW'(i))) begin
               errors++; $display("FAIL lat2_word[%0d]: rd %0d gap %0d @%0d=%h expected rd %0d gap 2 @%0d=%h",
                                  i, r1a[i], w1c[i] - r1c[i], w1a[i], w1d[i], i, 54 + i, f1(AW'(i)));
            end
         end
      end
      checks++; if (ww1 !== 24'd2 || err1 !== 1'b0) begin errors++; $display("FAIL lat2_words: got %0d err %b expected 2 0", ww1, err1); end
   endtask

   task automatic test_reset_mid_job();
      int nw, lat; bit to, bsy;
      r0a.delete(); w0a.delete(); w0d.delete(); w0c.delete();
      @(negedge clk);
      xa0 = 0; xb0 = 2; ya0 = 0; yb0 = 5; start0 = 1;
      @(posedge clk); #1; start0 = 0;
      @(posedge clk); @(posedge clk); #3;   // inside the first WRITE cycle
      checks++; if (if0.wr_en !== 1'b1) begin errors++; $display("FAIL midrst_pre: wr_en %b expected 1", if0.wr_en); end
      nw = w0a.size();
      rst_n = 0;
      #1;
      checks++;
      if ({busy0, done0, err0, if0.rd_en, if0.wr_en} !== 5'b0 || {if0.rd_addr, if0.wr_addr, if0.wr_data, ww0} !== '0) begin
         errors++; $display("FAIL midrst_outputs: ctrl %b rd_addr %0d wr_addr %0d wr_data %h ww %0d expected all 0",
                            {busy0, done0, err0, if0.rd_en, if0.wr_en}, if0.rd_addr, if0.wr_addr, if0.wr_data, ww0);
      end
      repeat (3) @(negedge clk);
      checks++; if (w0a.size() != nw) begin errors++; $display("FAIL midrst_writes: got %0d expected %0d", w0a.size(), nw); end
      rst_n = 1;
      do_job(0, 0, 0, 0, 0, 0, lat, to, bsy);
      checks++;
      if (to || lat != 8 || ww0 !== 24'd4 || w0a.size() != 4 || (w0a.size() > 0 && w0a[0] != 54)) begin
         errors++; $display("FAIL midrst_rerun: lat %0d words %0d writes %0d expected 8 4 4", lat, ww0, w0a.size());
      end
   endtask

   task automatic test_back_to_back();
      int lat; bit to, bsy;
      do_job(0, 1, 1, 0, 0, 3, lat, to, bsy);
      checks++; if (to || lat != 8) begin errors++; $display("FAIL held_latency: got %0d (timeout %b) expected 8", lat, to); end
      checks++;
      if (r0a.size() != 3 || (r0a.size() == 3 && (r0a[0] != 300 || r0a[2] != 302)) || ww0 !== 24'd4) begin
         errors++; $display("FAIL held_job: reads %0d first %0d words %0d expected 3 300 4", r0a.size(), r0a.size() ? r0a[0] : -1, ww0);
      end
      do_job(0, 0, 0, 0, 1, 0, lat, to, bsy);
      checks++; if (to || lat != 15) begin errors++; $display("FAIL restart_latency: got %0d (timeout %b) expected 15", lat, to); end
      checks++;
      if (w0a.size() != 8 || (w0a.size() == 8 && (w0a[0] != 54 || w0a[7] != 61 || w0d[6] !== 16'h0 || w0d[5] !== f0(24'd5)))) begin
         errors++; $display("FAIL restart_writes: count %0d first @%0d expected 8 writes 54..61", w0a.size(), w0a.size() ? w0a[0] : -1);
      end
      checks++; if (ww0 !== 24'd8 || err0 !== 1'b0) begin errors++; $display("FAIL restart_words: got %0d err %b expected 8 0", ww0, err0); end
   endtask

   initial begin
      #2;
      test_reset();
      test_default();
      test_single_pixel();
      test_reject();
      test_read_latency();
      test_reset_mid_job();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
